// File: rtl/sp_sram_port_ctrl.sv
// Single-port SRAM front end: arbitrates write/read valid-ready channels onto one
// macro port and returns read data through a 2-entry credit-protected response buffer.

module sp_sram_port_ctrl_chk (
  input logic       i_clock,
  input logic       i_reset,
  input logic       i_push,
  input logic       i_pop,
  input logic       i_inflight,
  input logic [1:0] i_occ
);

  // A push into a full buffer is only legal when the head leaves in the same cycle
  a_no_overflow: assert property (@(posedge i_clock) disable iff (i_reset)
    !(i_push && !i_pop && (i_occ == 2'd2)));

  a_occ_range: assert property (@(posedge i_clock) disable iff (i_reset)
    (i_occ <= 2'd2));

  a_credit: assert property (@(posedge i_clock) disable iff (i_reset)
    (({1'b0, i_occ} + {2'b00, i_inflight}) <= 3'd2));

  a_no_underflow: assert property (@(posedge i_clock) disable iff (i_reset)
    !(i_pop && (i_occ == 2'd0)));

endmodule

module sp_sram_port_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_sram_ceb,
  output logic              o_sram_web,
  output logic [ADDR_W-1:0] o_sram_a,
  output logic [DATA_W-1:0] o_sram_d,
  input  logic [DATA_W-1:0] i_sram_q
);

  logic              r_inflight;
  logic              r_prio;
  logic [1:0]        r_occ;
  logic              r_wptr;
  logic              r_rptr;
  logic [DATA_W-1:0] r_mem [2];

  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_credit;
  logic              w_rd_ok;
  logic              w_contend;
  logic              w_wr_gnt;
  logic              w_rd_gnt;

  assign w_pop    = (r_occ != 2'd0) & i_resp_ready;
  assign w_push   = r_inflight;

  // Reads already issued but not yet consumed, less the one leaving this cycle
  assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_ok  = (w_credit < 3'd2);

  assign w_contend = i_wr_valid & i_rd_valid & w_rd_ok;

  always_comb begin
    w_wr_gnt = 1'b0;
    w_rd_gnt = 1'b0;
    if (i_reset) begin
      w_wr_gnt = 1'b0;
      w_rd_gnt = 1'b0;
    end else if (w_contend) begin
      w_wr_gnt = ~r_prio;
      w_rd_gnt = r_prio;
    end else if (i_wr_valid) begin
      w_wr_gnt = 1'b1;
    end else if (i_rd_valid && w_rd_ok) begin
      w_rd_gnt = 1'b1;
    end else begin
      w_wr_gnt = 1'b0;
      w_rd_gnt = 1'b0;
    end
  end

  assign o_wr_ready = w_wr_gnt;
  assign o_rd_ready = w_rd_gnt;

  always_comb begin
    o_sram_ceb = 1'b1;
    o_sram_web = 1'b1;
    o_sram_a   = {ADDR_W{1'b0}};
    o_sram_d   = {DATA_W{1'b0}};
    case ({w_wr_gnt, w_rd_gnt})
      2'b10: begin
        o_sram_ceb = 1'b0;
        o_sram_web = 1'b0;
        o_sram_a   = i_wr_addr;
        o_sram_d   = i_wr_data;
      end
      2'b01: begin
        o_sram_ceb = 1'b0;
        o_sram_web = 1'b1;
        o_sram_a   = i_rd_addr;
        o_sram_d   = {DATA_W{1'b0}};
      end
      default: begin
        o_sram_ceb = 1'b1;
        o_sram_web = 1'b1;
        o_sram_a   = {ADDR_W{1'b0}};
        o_sram_d   = {DATA_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_inflight <= 1'b0;
      r_prio     <= 1'b0;
    end else begin
      r_inflight <= w_rd_gnt;
      r_prio     <= w_contend ? ~r_prio : r_prio;
    end
  end

  // sram_q is only meaningful the cycle after a read; any other cycle it is garbage
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_occ    <= 2'd0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_mem[0] <= {DATA_W{1'b0}};
      r_mem[1] <= {DATA_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_sram_q;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_resp_valid = (r_occ != 2'd0);
  assign o_resp_data  = r_mem[r_rptr];

  sp_sram_port_ctrl_chk u_chk (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_inflight (r_inflight),
    .i_occ      (r_occ)
  );

endmodule

// File: doc/sp_sram_port_ctrl.md
# sp_sram_port_ctrl

Request/response front end for one single-port SRAM macro (active-low CEB/WEB, 1-cycle registered read data, undefined Q on non-read cycles). It accepts independent valid/ready write and read channels from the cache/buffer logic. It arbitrates them onto the single port, one access per cycle, and returns read data through a 2-entry response buffer. The buffer holds data under backpressure and never captures Q on cycles that had no read.

## Interface
- ADDR_W, 7, SRAM address width (depth 2^ADDR_W)
- DATA_W, 8, SRAM data width
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wr_valid  in  1  write request present
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_valid  in  1  read request present
- rd_ready  out  1  read accepted this cycle
- rd_addr  in  ADDR_W  read address
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes read data
- resp_data  out  DATA_W  read data, oldest first
- sram_ceb  out  1  macro chip enable, active low
- sram_web  out  1  macro write enable, active low (1 = read)
- sram_a  out  ADDR_W  macro address
- sram_d  out  DATA_W  macro write data
- sram_q  in  DATA_W  macro registered read data

## Operation
- State: `inflight` (1 bit, read issued last cycle), response FIFO (2 entries, `occ` 0..2, rd/wr pointers), `prio` (0 = write wins next contention, 1 = read wins).
- Read eligibility: `rd_ok = (occ + inflight - (resp_valid & resp_ready)) < 2`. rd_ready depends combinationally on resp_ready. This is intended.
- Grant, combinational, at most one per cycle:
  - only wr_valid → write.
  - only rd_valid & rd_ok → read.
  - both valid & rd_ok → the side selected by prio; prio then flips to favour the loser.
  - wr_valid & rd_valid & !rd_ok → write; prio unchanged.
- Port drive:
  - write grant: ceb=0, web=0, a=wr_addr, d=wr_data.
  - read grant: ceb=0, web=1, a=rd_addr, d=0.
  - no grant: ceb=1, web=1, a=0, d=0.
- inflight <= read granted.
- When inflight=1, sram_q is pushed into the FIFO at the end of that cycle. sram_q is ignored in every other cycle, because the macro returns garbage there.
- Push and pop in the same cycle: occ unchanged, and the order is preserved. The credit rule guarantees a push never finds occ=2 without a simultaneous pop; an assertion checks this.
- resp_valid = (occ != 0). resp_data = FIFO head. Both are stable while resp_valid & !resp_ready.
- Reset: occ=0, pointers=0, inflight=0, prio=0. While reset=1: wr_ready=rd_ready=0, sram_ceb=1, sram_web=1. A read in flight or buffered at reset is discarded.

## Timing
- Write: accepted in cycle N, array updated at the end of N.
- Read: accepted in cycle N; sram_q valid in N+1; resp_valid first high in N+2. Latency is 2 cycles.
- Read after write to the same address accepted in a later cycle returns the new data.
- Sustained read throughput is 1/cycle when resp_ready=1. With resp_ready=0, at most 2 reads are accepted before rd_ready drops.
- Outputs after reset deassert: resp_valid=0, sram_ceb=1 until a request arrives.

## Test plan
- Write 0x5A@3, then read @3 with resp_ready=1: resp_valid rises 2 cycles after the read handshake, resp_data=0x5A, exactly one beat.
- Reads @0..7 back-to-back after writing data=addr^0xFF, resp_ready=1: rd_ready held high, responses 0xFF,0xFE,…,0xF8 in order, one per cycle.
- Same as previous with resp_ready=0: exactly 2 reads accepted, then rd_ready=0. Raise resp_ready: data drains in order, no loss or duplication, reads resume.
- wr_valid and rd_valid held high together for 6 cycles from reset: grants alternate W,R,W,R,W,R. sram_ceb=0 every cycle. A read of an address written earlier in the sequence returns the written value.
- Idle cycles with the macro Q randomising: resp_valid stays 0 and occ never changes.
- Assert reset one cycle after a read handshake, with one entry buffered: the next cycle shows resp_valid=0, wr_ready=rd_ready=0, sram_ceb=1. After release, a new read returns only its own data.
